// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the integer register file and its pending-write
// scoreboard: data width, register-address width, the x0 index and the
// register index/data types.
package regfile_scoreboard_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 1 << AW;

  typedef logic [AW-1:0]   reg_idx_t;
  typedef logic [XLEN-1:0] reg_data_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard_scoreboard_bits.sv
// Pending-write scoreboard for the register file.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   issue_en/issue_rd   mark issue_rd pending at the next edge
//   wb_en/wb_rd         clear wb_rd pending at the next edge
//   rs1_addr/rs2_addr   read-port addresses to report hazard status for
//   rs1_busy/rs2_busy   source has an outstanding write not retiring this cycle
//   pending_cnt         number of registers currently marked pending
module scoreboard_bits
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned NREG = regfile_scoreboard_pkg::NREG,
  parameter int unsigned AW   = regfile_scoreboard_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_en,
  input  logic [AW-1:0] issue_rd,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_rd,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic [AW:0]   pending_cnt
);

  logic [NREG-1:0] r_pending;
  logic [AW:0]     r_cnt;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_next;
  logic [AW:0]     w_cnt_next;
  logic            w_wb_valid;
  logic            w_issue_valid;

  assign w_wb_valid    = wb_en    && (wb_rd    != AW'(REG_ZERO));
  assign w_issue_valid = issue_en && (issue_rd != AW'(REG_ZERO));

  // Clear is applied before set, so a same-register issue+writeback leaves
  // the bit set: the new producer is still outstanding.
  always_comb begin
    w_clr = '0;
    w_set = '0;
    if (w_wb_valid)    w_clr[wb_rd]    = 1'b1;
    if (w_issue_valid) w_set[issue_rd] = 1'b1;
    w_next = (r_pending & ~w_clr) | w_set;
  end

  always_comb begin
    w_cnt_next = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      w_cnt_next = w_cnt_next + (AW+1)'(w_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
      r_cnt     <= '0;
    end else begin
      r_pending <= w_next;
      r_cnt     <= w_cnt_next;
    end
  end

  // A writeback retiring the source in this same cycle unblocks the reader.
  assign rs1_busy = r_pending[rs1_addr] &
                    ~(wb_en && (wb_rd == rs1_addr) && (rs1_addr != AW'(REG_ZERO)));
  assign rs2_busy = r_pending[rs2_addr] &
                    ~(wb_en && (wb_rd == rs2_addr) && (rs2_addr != AW'(REG_ZERO)));

  assign pending_cnt = r_cnt;

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file (NREG x XLEN) with two combinational read ports,
// one writeback port with same-cycle bypass, and a pending-write scoreboard.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   rs1_addr/rs2_addr   read addresses
//   rs1_data/rs2_data   read data (x0 reads 0, writeback bypassed)
//   rs1_busy/rs2_busy   source has an outstanding write
//   issue_en/issue_rd   decode marks destination pending
//   wb_en/wb_rd/wb_data writeback port
//   pending_cnt         number of registers currently pending
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN = regfile_scoreboard_pkg::XLEN,
  parameter int unsigned NREG = regfile_scoreboard_pkg::NREG,
  parameter int unsigned AW   = regfile_scoreboard_pkg::AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [AW:0]     pending_cnt
);

  logic [XLEN-1:0] r_regs [NREG];
  logic            w_wb_valid;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;

  assign w_wb_valid = wb_en && (wb_rd != AW'(REG_ZERO));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_valid) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    w_rs1_data = r_regs[rs1_addr];
    if (rs1_addr == AW'(REG_ZERO))             w_rs1_data = '0;
    else if (wb_en && (wb_rd == rs1_addr))     w_rs1_data = wb_data;
  end

  always_comb begin
    w_rs2_data = r_regs[rs2_addr];
    if (rs2_addr == AW'(REG_ZERO))             w_rs2_data = '0;
    else if (wb_en && (wb_rd == rs2_addr))     w_rs2_data = wb_data;
  end

  assign rs1_data = w_rs1_data;
  assign rs2_data = w_rs2_data;

  scoreboard_bits #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard_bits (
    .clk         (clk),
    .rst         (rst),
    .issue_en    (issue_en),
    .issue_rd    (issue_rd),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .pending_cnt (pending_cnt)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [5:0]  pending_cnt;

  regfile_scoreboard #(
    .XLEN (32),
    .NREG (32),
    .AW   (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .issue_en    (issue_en),
    .issue_rd    (issue_rd),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic        e_b1;
    logic        e_b2;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_no = 0;

  function automatic vec_t mk(input logic ie, input logic [4:0] ird,
                              input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                              input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic b1, input logic b2, input logic [5:0] c);
    vec_t v;
    v.issue_en = ie; v.issue_rd = ird; v.wb_en = we; v.wb_rd = wrd; v.wb_data = wd;
    v.rs1_addr = a1; v.rs2_addr = a2;
    v.e_rs1 = e1; v.e_rs2 = e2; v.e_b1 = b1; v.e_b2 = b2; v.e_cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a vector, queue its expectations, then compare once outputs settle.
  task automatic check_now(input vec_t v);
    vec_t e;
    issue_en = v.issue_en; issue_rd = v.issue_rd;
    wb_en = v.wb_en; wb_rd = v.wb_rd; wb_data = v.wb_data;
    rs1_addr = v.rs1_addr; rs2_addr = v.rs2_addr;
    exp_q.push_back(v);
    #2;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL v%0d.queue: got empty expected entry", vec_no);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d.rs1_data", vec_no), rs1_data, e.e_rs1);
      chk($sformatf("v%0d.rs2_data", vec_no), rs2_data, e.e_rs2);
      chk($sformatf("v%0d.rs1_busy", vec_no), {31'd0, rs1_busy}, {31'd0, e.e_b1});
      chk($sformatf("v%0d.rs2_busy", vec_no), {31'd0, rs2_busy}, {31'd0, e.e_b2});
      chk($sformatf("v%0d.pending_cnt", vec_no), {26'd0, pending_cnt}, {26'd0, e.e_cnt});
    end
    vec_no++;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    check_now(v);
  endtask

  initial begin
    rst = 1'b0;
    issue_en = 1'b0; issue_rd = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    rs1_addr = 5'd5; rs2_addr = 5'd31;

    // Table: mk(issue_en, issue_rd, wb_en, wb_rd, wb_data, rs1, rs2, e_rs1, e_rs2, e_b1, e_b2, e_cnt)
    tbl.push_back(mk(0,0, 0,0,32'h0,          5,31, 32'h0,32'h0,               0,0,0)); // 0 after reset
    tbl.push_back(mk(0,0, 1,3,32'hDEADBEEF,   5, 3, 32'h0,32'hDEADBEEF,        0,0,0)); // 1 bypass
    tbl.push_back(mk(0,0, 0,0,32'h0,          3, 0, 32'hDEADBEEF,32'h0,        0,0,0)); // 2 stored
    tbl.push_back(mk(1,0, 1,0,32'h7,          0, 0, 32'h0,32'h0,               0,0,0)); // 3 x0 wb+issue
    tbl.push_back(mk(0,0, 0,0,32'h0,          0, 0, 32'h0,32'h0,               0,0,0)); // 4 x0 unchanged
    tbl.push_back(mk(1,4, 0,0,32'h0,          4, 0, 32'h0,32'h0,               0,0,0)); // 5 issue not yet visible
    tbl.push_back(mk(1,4, 0,0,32'h0,          4, 0, 32'h0,32'h0,               1,0,1)); // 6 re-issue
    tbl.push_back(mk(0,0, 1,4,32'h9,          4, 4, 32'h9,32'h9,               0,0,1)); // 7 wb unblocks
    tbl.push_back(mk(0,0, 0,0,32'h0,          4, 0, 32'h9,32'h0,               0,0,0)); // 8 retired
    tbl.push_back(mk(1,6, 0,0,32'h0,          6, 0, 32'h0,32'h0,               0,0,0)); // 9
    tbl.push_back(mk(1,6, 1,6,32'h66,         6, 6, 32'h66,32'h66,             0,0,1)); // 10 same-reg issue+wb
    tbl.push_back(mk(1,8, 1,7,32'h77,         6, 7, 32'h66,32'h77,             1,0,1)); // 11 issue wins, diff regs
    tbl.push_back(mk(0,0, 0,0,32'h0,          8, 7, 32'h0,32'h77,              1,0,2)); // 12
    tbl.push_back(mk(0,0, 1,31,32'hA5A5A5A5, 31, 6, 32'hA5A5A5A5,32'h66,       0,1,2)); // 13 wb non-pending
    tbl.push_back(mk(0,0, 0,0,32'h0,         31, 8, 32'hA5A5A5A5,32'h0,        0,1,2)); // 14 no count change
    tbl.push_back(mk(0,0, 1,6,32'h1,          6, 8, 32'h1,32'h0,               0,1,2)); // 15
    tbl.push_back(mk(0,0, 1,8,32'h2,          8, 6, 32'h2,32'h1,               0,0,1)); // 16
    tbl.push_back(mk(0,0, 0,0,32'h0,          6, 8, 32'h1,32'h2,               0,0,0)); // 17

    repeat (2) @(posedge clk);
    #1;
    chk("reset.pending_cnt", {26'd0, pending_cnt}, 32'd0);
    chk("reset.rs1_data", rs1_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Async reset between issue and writeback.
    apply(mk(1,10, 0,0,32'h0,  3,10, 32'hDEADBEEF,32'h0, 0,0,0));
    apply(mk(1,11, 0,0,32'h0, 10, 0, 32'h0,32'h0,        1,0,1));
    apply(mk(0,0,  0,0,32'h0, 11,10, 32'h0,32'h0,        1,1,2));
    @(negedge clk);
    #1;
    rst = 1'b0;
    check_now(mk(0,0, 0,0,32'h0, 10, 3, 32'h0,32'h0,     0,0,0));
    @(negedge clk);
    rst = 1'b1;
    apply(mk(0,0, 1,10,32'h1, 10,11, 32'h1,32'h0,        0,0,0));
    apply(mk(0,0, 0,0,32'h0,  10,11, 32'h1,32'h0,        0,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Integer register file for the RV32 core: 32 x XLEN storage, two combinational read ports, one writeback port.
- Per-register pending-write scoreboard: decode marks a destination busy at issue; writeback clears it.
- Decode reads operands and hazard status here and stalls on busy sources.
- Writeback writes results here, using the same enable/data write semantics as the core's single registers.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; must be a power of two.
- AW, 5, register address width; equals log2(NREG).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset. rst=0 resets immediately; release is synchronous to clk.
- rs1_addr  input  AW  read port 1 address.
- rs2_addr  input  AW  read port 2 address.
- rs1_data  output  XLEN  read port 1 data, combinational.
- rs2_data  output  XLEN  read port 2 data, combinational.
- rs1_busy  output  1  register at rs1_addr has an outstanding write.
- rs2_busy  output  1  register at rs2_addr has an outstanding write.
- issue_en  input  1  decode issues an instruction that writes issue_rd.
- issue_rd  input  AW  destination to mark pending.
- wb_en  input  1  writeback strobe.
- wb_rd  input  AW  writeback destination.
- wb_data  input  XLEN  writeback value.
- pending_cnt  output  AW+1  number of registers currently marked pending.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers cleared to 0.
  - All pending bits cleared.
  - pending_cnt = 0.
  - Read outputs then reflect zeroed storage.
- x0:
  - Always reads 0 and is never busy.
  - wb_en with wb_rd=0 is ignored (no write, no pending change).
  - issue_en with issue_rd=0 is ignored.
- Write: on a rising clk with wb_en=1 and wb_rd!=0, reg[wb_rd] <= wb_data. Storage is otherwise held.
- Read (combinational):
  - rsX_data = 0 if rsX_addr=0.
  - Else wb_data if wb_en and wb_rd==rsX_addr (same-cycle bypass).
  - Else reg[rsX_addr].
- Busy (combinational):
  - rsX_busy = pending[rsX_addr] & ~(wb_en & wb_rd==rsX_addr & rsX_addr!=0).
  - A same-cycle writeback therefore unblocks the reader in that cycle.
  - A same-cycle issue is NOT visible; it becomes visible the next cycle.
- Pending update on each rising clk, applied in this order:
  - wb_en & wb_rd!=0 clears pending[wb_rd].
  - Then issue_en & issue_rd!=0 sets pending[issue_rd].
  - If issue and writeback target the same register in the same cycle, issue wins: the bit ends set, because a new producer is outstanding.
- pending_cnt:
  - Next value = popcount of next pending vector. May be implemented incrementally: +1 when a bit goes 0->1, -1 when a bit goes 1->0, net 0 for a simultaneous same-register clear and set.
  - Range 0..NREG-1; x0 is never counted.
  - Issue to an already-pending register: bit stays set, count unchanged.
  - Writeback to a non-pending register: data written, count unchanged, no underflow.
- Latency:
  - Written data is visible next cycle through storage; same cycle through the bypass.
  - Pending-bit changes are visible the cycle after the edge.
- Reset mid-operation:
  - Asserting rst between issue and writeback discards all pending state.
  - A later writeback still writes data and does not decrement below 0.

Decomposition:
- Shared core package holds:
  - XLEN and the register-address width.
  - The REG_ZERO constant (0).
  - A typedef for register index and register data.
- One natural sub-module: scoreboard_bits. It holds the pending vector, the set/clear priority logic and pending_cnt. The top level holds storage, the read muxes and the bypass.

Test Plan:
- Reset then reads: rst=0 for 2 cycles, then rst=1; rs1_addr=5, rs2_addr=31 -> rs1_data=0, rs2_data=0, both busy=0, pending_cnt=0.
- Write and read back: wb_en=1, wb_rd=3, wb_data=32'hDEADBEEF for one edge; next cycle rs1_addr=3 -> rs1_data=32'hDEADBEEF. Also check the same-cycle bypass: rs2_addr=3 during the write cycle -> rs2_data=32'hDEADBEEF.
- x0 protection: wb_en=1, wb_rd=0, wb_data=7, plus issue_en=1, issue_rd=0 -> rs1_addr=0 reads 0, rs1_busy=0, pending_cnt=0.
- Scoreboard lifecycle:
  - issue_en, issue_rd=4 -> next cycle rs1_addr=4 gives rs1_busy=1, pending_cnt=1.
  - Issue rd=4 again -> pending_cnt stays 1.
  - wb rd=4, data=9 -> that cycle rs1_busy=0 and rs1_data=9; next cycle pending_cnt=0.
- Simultaneous issue and writeback: with pending[6]=1, same cycle wb_rd=6 and issue_rd=6 -> pending[6] stays 1, pending_cnt unchanged. With pending[7]=0, same cycle issue_rd=8 and wb_rd=7 -> pending_cnt +1.
- Async reset mid-flight: issue rd=10 and rd=11 (pending_cnt=2), then assert rst=0 between edges -> pending_cnt=0 and busy=0 immediately, storage 0. After release, wb rd=10 data=1 -> reg10=1, pending_cnt=0.
